// File: rtl/ccip_operand_fetch_pkg.sv
// Shared types for the CCI-P operand-fetch stage: FSM states, mdata tags and
// mdata pack/unpack helpers (64-bit wide; callers size-cast to MDATA_W).
package ccip_operand_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ_A = 3'd1,
        REQ_B = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } t_fetch_state;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    // mdata layout is {seq, tag}; the tag sits in bit 0.
    function automatic logic [63:0] pack_mdata(input logic [63:0] seq, input logic tag);
        return 64'({seq, tag});
    endfunction

    function automatic logic [63:0] mdata_seq(input logic [63:0] mdata);
        return mdata >> 1;
    endfunction

    function automatic logic mdata_tag(input logic [63:0] mdata);
        return mdata[0];
    endfunction

endpackage

// File: rtl/ccip_rsp_tag_match.sv
// Combinational compare of a c0 read response tag against the live command
// sequence number; produces per-operand hits.
module ccip_rsp_tag_match
    import ccip_operand_fetch_pkg::*;
#(
    parameter int MDATA_W = 16
) (
    input  logic               rsp_valid,
    input  logic               capture_en,
    input  logic [MDATA_W-1:0] rsp_mdata,
    input  logic [MDATA_W-2:0] cur_seq,
    output logic               hit_a,
    output logic               hit_b
);

    logic seq_match;
    logic rsp_tag;
    logic take;

    always_comb begin
        seq_match = ((MDATA_W-1)'(mdata_seq(64'(rsp_mdata))) == cur_seq);
        rsp_tag   = mdata_tag(64'(rsp_mdata));
        take      = rsp_valid && capture_en && seq_match;
        hit_a     = take && (rsp_tag == TAG_A);
        hit_b     = take && (rsp_tag == TAG_B);
    end

endmodule

// File: rtl/ccip_operand_fetch.sv
// Operand-fetch stage: issues two c0 reads per start, gathers both responses in
// any order and hands the operand pair downstream. Watchdog: OPERAND_FETCH_TIMEOUT_EN.
module ccip_operand_fetch
    import ccip_operand_fetch_pkg::*;
#(
    parameter int CL_ADDR_W      = 42,
    parameter int CL_DATA_W      = 512,
    parameter int MDATA_W        = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CL_ADDR_W-1:0] addr_a,
    input  logic [CL_ADDR_W-1:0] addr_b,
    output logic                 busy,
    input  logic                 c0_tx_alm_full,
    output logic                 c0_tx_valid,
    output logic [CL_ADDR_W-1:0] c0_tx_addr,
    output logic [MDATA_W-1:0]   c0_tx_mdata,
    input  logic                 c0_rx_rsp_valid,
    input  logic [MDATA_W-1:0]   c0_rx_mdata,
    input  logic [CL_DATA_W-1:0] c0_rx_data,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [CL_DATA_W-1:0] op_a,
    output logic [CL_DATA_W-1:0] op_b,
    output logic                 err,
    output t_fetch_state         dbg_state
);

    // Handshakes: a request transfers in every cycle c0_tx_valid=1 (the stage
    // only raises it when c0_tx_alm_full=0); the operand pair transfers on the
    // rising edge where op_valid && op_ready, and op_a/op_b hold until then.

    t_fetch_state         state_q, state_d;
    logic [MDATA_W-2:0]   seq_q, seq_d;
    logic [MDATA_W-2:0]   cur_seq_q, cur_seq_d;
    logic [CL_ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [CL_ADDR_W-1:0] addr_b_q, addr_b_d;
    logic                 got_a_q, got_a_d;
    logic                 got_b_q, got_b_d;
    logic [CL_DATA_W-1:0] op_a_q, op_a_d;
    logic [CL_DATA_W-1:0] op_b_q, op_b_d;
    logic                 op_valid_q, op_valid_d;
    logic                 c0_tx_valid_q, c0_tx_valid_d;
    logic [CL_ADDR_W-1:0] c0_tx_addr_q, c0_tx_addr_d;
    logic [MDATA_W-1:0]   c0_tx_mdata_q, c0_tx_mdata_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 capture_en;
    logic                 hit_a, hit_b;

`ifdef OPERAND_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    assign capture_en = (state_q == REQ_B) || (state_q == WAIT);

    ccip_rsp_tag_match #(
        .MDATA_W (MDATA_W)
    ) u_tag_match (
        .rsp_valid  (c0_rx_rsp_valid),
        .capture_en (capture_en),
        .rsp_mdata  (c0_rx_mdata),
        .cur_seq    (cur_seq_q),
        .hit_a      (hit_a),
        .hit_b      (hit_b)
    );

    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        cur_seq_d     = cur_seq_q;
        addr_a_d      = addr_a_q;
        addr_b_d      = addr_b_q;
        got_a_d       = got_a_q;
        got_b_d       = got_b_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        c0_tx_valid_d = 1'b0;
        c0_tx_addr_d  = c0_tx_addr_q;
        c0_tx_mdata_d = c0_tx_mdata_q;
        err_d         = 1'b0;

        // Duplicates overwrite data; the got flag simply stays set.
        if (hit_a) begin
            op_a_d  = c0_rx_data;
            got_a_d = 1'b1;
        end
        if (hit_b) begin
            op_b_d  = c0_rx_data;
            got_b_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = REQ_A;
                    addr_a_d  = addr_a;
                    addr_b_d  = addr_b;
                    cur_seq_d = seq_q;
                    seq_d     = seq_q + (MDATA_W-1)'(1);
                    got_a_d   = 1'b0;
                    got_b_d   = 1'b0;
                end
            end
            REQ_A: begin
                if (!c0_tx_alm_full) begin
                    state_d       = REQ_B;
                    c0_tx_valid_d = 1'b1;
                    c0_tx_addr_d  = addr_a_q;
                    c0_tx_mdata_d = MDATA_W'(pack_mdata(64'(cur_seq_q), TAG_A));
                end
            end
            REQ_B: begin
                if (!c0_tx_alm_full) begin
                    state_d       = WAIT;
                    c0_tx_valid_d = 1'b1;
                    c0_tx_addr_d  = addr_b_q;
                    c0_tx_mdata_d = MDATA_W'(pack_mdata(64'(cur_seq_q), TAG_B));
                end
            end
            WAIT: begin
                if (got_a_q && got_b_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (op_valid_q && op_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef OPERAND_FETCH_TIMEOUT_EN
        timer_d = timer_q;
        if (state_q == IDLE && start) begin
            timer_d = '0;
        end else if (capture_en) begin
            timer_d = timer_q + TW'(1);
        end
        if (capture_en && timer_q == TW'(TIMEOUT_CYCLES - 1) && !(got_a_q && got_b_q)) begin
            state_d       = IDLE;
            got_a_d       = 1'b0;
            got_b_d       = 1'b0;
            c0_tx_valid_d = 1'b0;
            err_d         = 1'b1;
        end
`endif

        op_valid_d = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            seq_q         <= '0;
            cur_seq_q     <= '0;
            addr_a_q      <= '0;
            addr_b_q      <= '0;
            got_a_q       <= 1'b0;
            got_b_q       <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_valid_q    <= 1'b0;
            c0_tx_valid_q <= 1'b0;
            c0_tx_addr_q  <= '0;
            c0_tx_mdata_q <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            seq_q         <= seq_d;
            cur_seq_q     <= cur_seq_d;
            addr_a_q      <= addr_a_d;
            addr_b_q      <= addr_b_d;
            got_a_q       <= got_a_d;
            got_b_q       <= got_b_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_valid_q    <= op_valid_d;
            c0_tx_valid_q <= c0_tx_valid_d;
            c0_tx_addr_q  <= c0_tx_addr_d;
            c0_tx_mdata_q <= c0_tx_mdata_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

`ifdef OPERAND_FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign busy        = busy_q;
    assign c0_tx_valid = c0_tx_valid_q;
    assign c0_tx_addr  = c0_tx_addr_q;
    assign c0_tx_mdata = c0_tx_mdata_q;
    assign op_valid    = op_valid_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign err         = err_q;
    assign dbg_state   = state_q;

endmodule
